// File: rtl/uart_port_core.sv
// uart_port_core: single-clock 8N1 UART with an indexed receive buffer
// and a transmitter driven by a requested byte count.
module uart_port_core #(
    parameter int CLK_HZ   = 21428000,
    parameter int BAUD     = 115200,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_port_DI,
    output logic        uart_port_DO,
    input  logic [15:0] read_ptr,
    output logic [7:0]  uart_DO,
    output logic        read_valid,
    input  logic        rx_clear,
    input  logic [7:0]  tx_DI,
    input  logic [15:0] send_ptr,
    input  logic        tx_clear,
    output logic        send_valid
);

    localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam int AW   = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [16:0]   DEPTH   = 17'(RX_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          sync1_q, sync2_q, prev_q;
    logic [1:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [16:0]   rx_count_q, rx_count_d;
    logic [7:0]    buf_q [RX_DEPTH];
    logic [7:0]    buf_d [RX_DEPTH];
    logic          rx_store;

    logic [1:0]    tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic [15:0]   tx_count_q, tx_count_d;
    logic          tx_line_q, tx_line_d;
    logic          tx_go;

    // Synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= uart_port_DI;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_store   = 1'b0;
        unique case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (prev_q && !sync2_q) rx_state_d = S_START;
            end
            S_START: begin
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = sync2_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == DIV_M1) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == DIV_M1) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_IDLE;
                    rx_store   = sync2_q;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // Clear wins over a same-cycle store; a full buffer drops the byte.
    always_comb begin
        rx_count_d = rx_count_q;
        buf_d      = buf_q;
        if (rx_clear) begin
            rx_count_d = '0;
        end else if (rx_store && rx_count_q < DEPTH) begin
            buf_d[rx_count_q[AW-1:0]] = rx_shift_q;
            rx_count_d = rx_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_count_q <= '0;
            for (int i = 0; i < RX_DEPTH; i++) buf_q[i] <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_count_q <= rx_count_d;
            buf_q      <= buf_d;
        end
    end

    assign read_valid = {1'b0, read_ptr} < rx_count_q;
    assign uart_DO    = ({1'b0, read_ptr} < DEPTH) ?
                        buf_q[read_ptr[AW-1:0]] : 8'h00;

    // A new frame may start straight out of the last stop-bit clock.
    assign tx_go = (tx_count_q < send_ptr) &&
                   (tx_state_q == S_IDLE ||
                    (tx_state_q == S_STOP && tx_cnt_q == DIV_M1));

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        unique case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d  = '0;
                tx_line_d = 1'b1;
            end
            S_START: begin
                if (tx_cnt_q == DIV_M1) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = S_DATA;
                    tx_line_d  = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                end
            end
            S_DATA: begin
                if (tx_cnt_q == DIV_M1) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = tx_bit_q + 1'b1;
                    tx_line_d  = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                        tx_line_d  = 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (tx_cnt_q == DIV_M1) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_IDLE;
                    tx_line_d  = 1'b1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        if (tx_go) begin
            tx_state_d = S_START;
            tx_cnt_d   = '0;
            tx_line_d  = 1'b0;
            tx_shift_d = tx_DI;
        end
    end

    always_comb begin
        tx_count_d = tx_count_q;
        if (tx_clear)   tx_count_d = '0;
        else if (tx_go) tx_count_d = tx_count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_count_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_count_q <= tx_count_d;
            tx_line_q  <= tx_line_d;
        end
    end

    assign uart_port_DO = tx_line_q;
    assign send_valid   = (tx_state_q == S_IDLE) && (tx_count_q >= send_ptr);

endmodule

// File: tb/tb_uart_port_core.sv
// tb_uart_port_core: table vectors for the RX buffer, a serial decoder
// with an expected-byte queue for the TX line.
module tb_uart_port_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_pin = 1'b1;
    logic        loop_en = 1'b0;
    logic        di;
    logic        dout;
    logic [15:0] read_ptr = '0;
    logic [7:0]  uart_DO;
    logic        read_valid;
    logic        rx_clear = 1'b0;
    logic [7:0]  tx_DI = '0;
    logic [15:0] send_ptr = '0;
    logic        tx_clear = 1'b0;
    logic        send_valid;

    assign di = loop_en ? dout : rx_pin;

    uart_port_core #(
        .CLK_HZ(1000000),
        .BAUD(100000),
        .RX_DEPTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .uart_port_DI(di),
        .uart_port_DO(dout),
        .read_ptr(read_ptr),
        .uart_DO(uart_DO),
        .read_valid(read_valid),
        .rx_clear(rx_clear),
        .tx_DI(tx_DI),
        .send_ptr(send_ptr),
        .tx_clear(tx_clear),
        .send_valid(send_valid)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int t0;
    logic mon_en = 1'b0;
    logic [7:0] exp_q[$];
    int starts[$];

    typedef struct {
        logic [15:0] ptr;
        logic        vld;
        logic [7:0]  data;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stp);
        logic [9:0] f;
        f = {stp, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 rx_pin = f[i];
            if (i == 0) t0 = cyc;
            repeat (9) @(posedge clk);
        end
    endtask

    task automatic pulse_rx_clear();
        @(negedge clk) rx_clear = 1'b1;
        @(negedge clk) rx_clear = 1'b0;
    endtask

    // Serial decoder on the TX line, sampling mid-bit on falling clock.
    initial begin
        logic prev;
        logic sb, stp;
        logic [7:0] b;
        logic [7:0] e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev && !dout) begin
                starts.push_back(cyc);
                repeat (5) @(negedge clk);
                sb = dout;
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge clk);
                    b[i] = dout;
                end
                repeat (10) @(negedge clk);
                stp = dout;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected_frame actual=%0h expected=none",
                             {sb, b, stp});
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_frame", {22'd0, sb, b, stp}, {22'd0, 1'b0, e, 1'b1});
                end
            end
            prev = dout;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, t, c0, lowcnt;

        // Reset state
        @(negedge clk);
        chk("rst_dout", dout, 1);
        chk("rst_read_valid", read_valid, 0);
        chk("rst_send_valid", send_valid, 1);
        chk("rst_uart_DO", uart_DO, 0);
        @(negedge clk) rst = 1'b0;

        // RX single byte with latency
        lat = -1;
        fork
            rx_frame(8'hA5, 1'b1);
            begin
                t = -1;
                for (int k = 0; k < 150; k++) begin
                    @(negedge clk);
                    if (read_valid) begin
                        t = cyc;
                        break;
                    end
                end
                if (t >= 0) lat = t - t0;
            end
        join
        chk("rx_latency_98", (lat >= 97 && lat <= 99), 1);
        chk("rx_a5_data", uart_DO, 8'hA5);
        @(negedge clk) read_ptr = 16'd1;
        #1 chk("rx_ptr1_invalid", read_valid, 0);
        read_ptr = 16'd0;

        // Reset in the middle of a TX frame
        tx_DI = 8'h00;
        send_ptr = 16'd1;
        repeat (30) @(negedge clk);
        chk("tx_mid_frame_low", dout, 0);
        #1 rst = 1'b1;
        send_ptr = 16'd0;
        #1;
        chk("midrst_dout", dout, 1);
        chk("midrst_read_valid", read_valid, 0);
        chk("midrst_uart_DO", uart_DO, 0);
        chk("midrst_send_valid", send_valid, 1);
        @(negedge clk) rst = 1'b0;

        // 3-clock glitch is rejected
        @(posedge clk);
        #1 rx_pin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx_pin = 1'b1;
        repeat (120) @(posedge clk);
        chk("glitch_no_byte", read_valid, 0);

        // Framing error is discarded
        rx_frame(8'h81, 1'b0);
        @(posedge clk);
        #1 rx_pin = 1'b1;
        repeat (20) @(posedge clk);
        chk("framing_no_byte", read_valid, 0);

        rx_frame(8'h5A, 1'b1);
        repeat (20) @(negedge clk);
        chk("after_err_valid", read_valid, 1);
        chk("after_err_data", uart_DO, 8'h5A);
        read_ptr = 16'd1;
        #1 chk("after_err_ptr1", read_valid, 0);
        read_ptr = 16'd0;
        pulse_rx_clear();
        #1 chk("clear_valid0", read_valid, 0);

        // Clear coincident with the store clock wins
        fork
            rx_frame(8'h77, 1'b1);
            begin
                @(posedge clk);
                repeat (97) @(posedge clk);
                #1 rx_clear = 1'b1;
                @(posedge clk);
                #1 rx_clear = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        chk("clear_prio_valid", read_valid, 0);
        chk("clear_prio_data", uart_DO, 8'h5A);

        // Overflow: 17 bytes into 16 entries
        for (int b = 0; b < 17; b++) rx_frame(8'(b), 1'b1);
        repeat (20) @(negedge clk);
        vt[0] = '{16'd0,   1'b1, 8'h00};
        vt[1] = '{16'd1,   1'b1, 8'h01};
        vt[2] = '{16'd7,   1'b1, 8'h07};
        vt[3] = '{16'd14,  1'b1, 8'h0E};
        vt[4] = '{16'd15,  1'b1, 8'h0F};
        vt[5] = '{16'd16,  1'b0, 8'h00};
        vt[6] = '{16'd200, 1'b0, 8'h00};
        vt[7] = '{16'hFFFF, 1'b0, 8'h00};
        for (int i = 0; i < 8; i++) begin
            read_ptr = vt[i].ptr;
            #1;
            chk($sformatf("ovf_valid_%0d", vt[i].ptr), read_valid, vt[i].vld);
            chk($sformatf("ovf_data_%0d", vt[i].ptr), uart_DO, vt[i].data);
        end
        pulse_rx_clear();
        for (int i = 0; i < 8; i++) begin
            read_ptr = vt[i].ptr;
            #1;
            chk($sformatf("clr_valid_%0d", vt[i].ptr), read_valid, 0);
            chk($sformatf("clr_data_%0d", vt[i].ptr), uart_DO, vt[i].data);
        end
        read_ptr = 16'd0;

        // TX count: two back-to-back frames
        mon_en = 1'b1;
        @(negedge clk);
        chk("tx_idle_send_valid", send_valid, 1);
        starts.delete();
        tx_DI = 8'h3C;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h3C);
        send_ptr = 16'd2;
        c0 = cyc;
        @(negedge clk);
        chk("tx_busy_send_valid", send_valid, 0);
        t = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (send_valid) begin
                t = cyc;
                break;
            end
        end
        chk("tx_total_cycles", t - c0, 201);
        repeat (5) @(negedge clk);
        chk("tx_frame_count", starts.size(), 2);
        if (starts.size() == 2) begin
            chk("tx_start_latency", starts[0] - c0, 1);
            chk("tx_zero_gap", starts[1] - starts[0], 100);
        end
        chk("tx_sb_empty", exp_q.size(), 0);

        // Loopback blast, then drop send_ptr mid-frame
        pulse_rx_clear();
        loop_en = 1'b1;
        starts.delete();
        tx_DI = 8'hC3;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'hC3);
        tx_clear = 1'b1;
        send_ptr = 16'd1;
        repeat (350) @(negedge clk);
        send_ptr = 16'd0;
        repeat (60) @(negedge clk);
        lowcnt = 0;
        repeat (150) begin
            @(negedge clk);
            if (!dout) lowcnt++;
        end
        chk("blast_idle_after_drop", lowcnt, 0);
        chk("blast_frames", starts.size(), 4);
        chk("blast_sb_empty", exp_q.size(), 0);
        if (starts.size() == 4)
            chk("blast_gap", starts[3] - starts[0], 300);
        chk("blast_send_valid", send_valid, 1);
        tx_clear = 1'b0;
        read_ptr = 16'd3;
        #1;
        chk("loop_rx_valid3", read_valid, 1);
        chk("loop_rx_data3", uart_DO, 8'hC3);
        read_ptr = 16'd4;
        #1 chk("loop_rx_valid4", read_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
